lmac_reg_rd_initiator: RTL

//  Host-side initiator for the MAC register-read port (host_addr_reg / reg_rd_start / reg_rd_done_out / FMAC_REGDOUT).

---
 rtl/lmac_reg_rd_initiator.sv | 99 +++++++++
 1 files changed

// File: rtl/lmac_reg_rd_initiator.sv
// lmac_reg_rd_initiator: issues burst register reads on the MAC host port and returns each word on a response channel.
// Optional WAIT_DONE timeout is built when LMAC_RDREQ_TIMEOUT_EN is defined.
module lmac_reg_rd_initiator #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int LEN_W          = 8,
   parameter int ADDR_STRIDE    = 4,
   parameter int GAP_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              rsp_last,
   output logic              busy,
   output logic [ADDR_W-1:0] host_addr_reg,
   output logic              reg_rd_start,
   input  logic              reg_rd_done_out,
   input  logic [DATA_W-1:0] FMAC_REGDOUT
);
   typedef enum logic [2:0] {IDLE, START, WAIT_DONE, RESP, GAP} state_t;
   localparam int GW = $clog2(GAP_CYCLES + 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  remaining;
   logic [GW-1:0]     gap_cnt;
   logic              done_hit, expire;

   assign done_hit = (state == WAIT_DONE) && reg_rd_done_out;

`ifdef LMAC_RDREQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   // Held at zero outside WAIT_DONE, so every read starts its own count.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) tmo_cnt <= '0;
      else tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 1'b1 : '0;
   assign expire = (state == WAIT_DONE) && !reg_rd_done_out && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign expire = 1'b0;
`endif

   assign req_ready     = (state == IDLE);
   assign busy          = (state != IDLE);
   assign reg_rd_start  = (state == START) || (state == WAIT_DONE);
   assign rsp_valid     = (state == RESP);
   assign host_addr_reg = cur_addr;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (req_valid) state_nx = START;
         START:     state_nx = WAIT_DONE;
         WAIT_DONE: if (done_hit || expire) state_nx = RESP;
         RESP:      if (rsp_ready) state_nx = rsp_last ? IDLE : GAP;
         GAP:       if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = START;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         gap_cnt   <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         rsp_last  <= 1'b0;
      end else begin
         state   <= state_nx;
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
         if (state == IDLE && req_valid) begin
            cur_addr  <= req_addr;
            remaining <= req_len;
         end
         if (done_hit) begin
            rsp_data <= FMAC_REGDOUT;
            rsp_err  <= 1'b0;
            rsp_last <= (remaining == '0);
         end else if (expire) begin
            rsp_data <= {DATA_W/32{32'hDEADBEEF}};
            rsp_err  <= 1'b1;
            rsp_last <= 1'b1;
         end
         if (state == RESP && rsp_ready && !rsp_last) begin
            remaining <= remaining - 1'b1;
            cur_addr  <= cur_addr + ADDR_W'(ADDR_STRIDE);
         end
      end
endmodule
